multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT_CYCLES, default 255, giving the maximum wait cycles for mem_ready per memory access (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port instr, input, 32, the instruction register contents; opcode is instr[6:0].
REQ-005 The block SHALL have port mem_ready, input, 1, memory completion for the current request.
REQ-006 The block SHALL have port alu_zero, input, 1, the ALU zero flag.
REQ-007 The block SHALL have port mem_req, output, 1, memory request strobe.
REQ-008 The block SHALL have port mem_we, output, 1, store qualifier for mem_req.
REQ-009 The block SHALL have port addr_sel, output, 1, memory address source: 0=PC, 1=ALU result.
REQ-010 The block SHALL have port ir_we, output, 1, instruction register load strobe.
REQ-011 The block SHALL have port pc_we, output, 1, PC load strobe.
REQ-012 The block SHALL have port pc_sel, output, 2, next-PC source: 0=PC+4, 1=branch target, 2=jump target.
REQ-013 The block SHALL have port alu_op, output, 3, ALU operation code; 3'b000 = add.
REQ-014 The block SHALL have port alu_b_sel, output, 1, ALU B operand source: 0=rs2, 1=immediate.
REQ-015 The block SHALL have port reg_we, output, 1, register-file write strobe.
REQ-016 The block SHALL have port wb_sel, output, 2, writeback source: 0=ALU, 1=memory data, 2=PC+4.
REQ-017 The block SHALL have port err, output, 1, sticky memory-timeout flag.
REQ-018 The block SHALL have port trap, output, 1, sticky illegal-instruction flag; present only under the configuration macro.

Function
REQ-019 States SHALL be FETCH, DECODE, EXEC, MEM, WB and ERROR, plus TRAP under the macro. Outputs SHALL be decoded from the state and instr only (Moore + opcode).
REQ-020 FETCH SHALL hold mem_req=1, mem_we=0, addr_sel=0. On mem_ready=1 it SHALL pulse ir_we=1 and pc_we=1 with pc_sel=0, then go to DECODE.
REQ-021 DECODE SHALL last exactly one cycle with all strobes 0, then go to EXEC.
REQ-022 EXEC SHALL drive alu_op and alu_b_sel per opcode: LOAD 0000011 and STORE 0100011 use add with immediate; OP-IMM 0010011 uses immediate; OP 0110011 uses rs2; BRANCH 1100011 uses subtract with rs2.
REQ-023 EXEC next state SHALL be: LOAD/STORE -> MEM; OP/OP-IMM -> WB; BRANCH -> FETCH with pc_we=alu_zero and pc_sel=1; JAL 1101111 -> WB with pc_we=1 and pc_sel=2.
REQ-024 MEM SHALL hold mem_req=1, addr_sel=1, mem_we=(STORE). On mem_ready a STORE SHALL go to FETCH and a LOAD SHALL go to WB.
REQ-025 WB SHALL pulse reg_we=1 for one cycle, with wb_sel=1 for LOAD, 2 for JAL and 0 otherwise, then go to FETCH.
REQ-026 mem_req, mem_we and addr_sel SHALL stay stable from request until the cycle mem_ready is sampled high. mem_ready SHALL be ignored outside FETCH/MEM.
REQ-027 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready=0. When the count reaches MEM_TIMEOUT_CYCLES the block SHALL go to ERROR.
REQ-028 mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT_CYCLES SHALL count as success.
REQ-029 ERROR SHALL drive all strobes 0 and err=1, and SHALL be left only by reset.
REQ-030 Latencies: ALU instruction 4 cycles plus fetch wait; load 5 cycles plus waits; store 4 cycles plus waits; branch 3 cycles plus fetch wait.

Reset
REQ-031 While rst=1, the state SHALL be FETCH, the counter 0, and every output 0, including mem_req, err and trap.
REQ-032 Reset asserted mid-access SHALL abandon the access with no strobe. mem_req SHALL rise the first cycle after rst falls.

Configuration
REQ-033 With MULTICYCLE_CTRL_TRAP_EN defined, an unknown opcode in EXEC SHALL go to TRAP, with trap=1 and all strobes 0, held until reset.
REQ-034 Without MULTICYCLE_CTRL_TRAP_EN, an unknown opcode SHALL be a NOP returning to FETCH, and the trap port and TRAP state SHALL be absent.

Structure
REQ-035 Package cpu_pkg SHALL hold the alu_op enum (ADD=000, SUB=001, ...), the opcode constants, the state enum, and the pc_sel/wb_sel encodings.
REQ-036 Opcode-to-control decoding SHALL be a combinational sub-module, ctrl_decode.

Verification
REQ-037 ADDI (instr=0x00500093), mem_ready=1 on the first FETCH cycle: ir_we at cycle 0, reg_we at cycle 3, wb_sel=0, alu_b_sel=1.
REQ-038 LW with mem_ready delayed 3 cycles in MEM: mem_req high 4 cycles with addr_sel=1, then reg_we once with wb_sel=1.
REQ-039 BEQ with alu_zero=1, then with alu_zero=0: pc_we=1/pc_sel=1 in EXEC for the first; pc_we=0 for the second.
REQ-040 MEM_TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH: ERROR entered after 4 wait cycles, err=1, mem_req=0; a later mem_ready has no effect.
REQ-041 Opcode 0x7F, with and without the macro: trap=1 sticky vs. next FETCH with no reg_we.
REQ-042 rst pulsed during a MEM wait: all outputs 0 during reset, then FETCH with mem_req=1 and addr_sel=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared encodings for the multicycle controller.
//
// Holds the ALU operation enum, the RV32 major-opcode constants used by the
// decoder, the controller state enum and the pc_sel / wb_sel encodings.
//
// Configuration macro: MULTICYCLE_CTRL_TRAP_EN adds the TRAP state.

package cpu_pkg;

    // ALU_FUNCT tells the datapath to take the operation from funct3/funct7.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , ST_TRAP = 3'd6
`endif
    } state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational opcode classifier for the multicycle controller.
//
// Ports:
//   opcode    in  [6:0]  instr[6:0]
//   legal     out        opcode is one the controller implements
//   is_load / is_store / is_branch / is_jal / is_alu  out  instruction class
//   alu_op    out [2:0]  ALU operation used in EXEC
//   alu_b_sel out        0 = rs2, 1 = immediate
//   wb_sel    out [1:0]  writeback source used in WB

module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_alu,
    output logic [2:0] alu_op,
    output logic       alu_b_sel,
    output logic [1:0] wb_sel
);

    // Unknown opcodes fall through with everything cleared; the controller
    // decides whether that means a NOP or a trap.
    always_comb begin
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_alu    = 1'b0;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        wb_sel    = WB_SEL_ALU;
        unique case (opcode)
            OPC_LOAD: begin
                legal     = 1'b1;
                is_load   = 1'b1;
                alu_b_sel = 1'b1;
                wb_sel    = WB_SEL_MEM;
            end
            OPC_STORE: begin
                legal     = 1'b1;
                is_store  = 1'b1;
                alu_b_sel = 1'b1;
            end
            OPC_OP_IMM: begin
                legal     = 1'b1;
                is_alu    = 1'b1;
                alu_op    = ALU_FUNCT;
                alu_b_sel = 1'b1;
            end
            OPC_OP: begin
                legal  = 1'b1;
                is_alu = 1'b1;
                alu_op = ALU_FUNCT;
            end
            OPC_BRANCH: begin
                legal     = 1'b1;
                is_branch = 1'b1;
                alu_op    = ALU_SUB;
            end
            OPC_JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
                wb_sel = WB_SEL_PC4;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle RV32 datapath.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr [31:0]    instruction register (opcode = instr[6:0])
//   mem_ready       memory completion, only looked at in FETCH / MEM
//   alu_zero        ALU zero flag, used to resolve branches in EXEC
//   mem_req, mem_we, addr_sel        memory request interface
//   ir_we, pc_we, pc_sel [1:0]       instruction / PC update strobes
//   alu_op [2:0], alu_b_sel          ALU control
//   reg_we, wb_sel [1:0]             register writeback
//   err             sticky memory-timeout flag
//   trap            sticky illegal-instruction flag (MULTICYCLE_CTRL_TRAP_EN only)
//
// Parameter MEM_TIMEOUT_CYCLES (1..255): wait cycles allowed per access.
// Configuration macro: MULTICYCLE_CTRL_TRAP_EN.

module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  alu_op,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        err
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , output logic      trap
`endif
);

    // The access times out on the cycle whose wait would bring the count to
    // MEM_TIMEOUT_CYCLES; a mem_ready in that same cycle still wins.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic       dec_legal, dec_load, dec_store, dec_branch, dec_jal, dec_alu;
    logic [2:0] dec_alu_op;
    logic       dec_alu_b_sel;
    logic [1:0] dec_wb_sel;

    // Only the opcode field steers control; the rest belongs to the datapath.
    logic instr_unused;
    assign instr_unused = ^instr[31:7];

    ctrl_decode u_decode (
        .opcode    (instr[6:0]),
        .legal     (dec_legal),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch),
        .is_jal    (dec_jal),
        .is_alu    (dec_alu),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_alu_b_sel),
        .wb_sel    (dec_wb_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The wait counter only advances while FETCH/MEM is stalled; every other
    // path clears it, so each access starts counting from zero.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_load || dec_store) begin
                    state_d = ST_MEM;
                end else if (dec_branch) begin
                    state_d = ST_FETCH;
                end else if (dec_alu || dec_jal) begin
                    state_d = ST_WB;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = dec_store ? ST_FETCH : ST_WB;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs follow the state and opcode; the FETCH strobes are qualified by
    // mem_ready and the branch PC write by alu_zero. Everything is forced low
    // while rst is high so an interrupted access produces no strobe.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        err       = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap      = 1'b0;
`endif
        if (!rst) begin
            unique case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                ST_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_b_sel = dec_alu_b_sel;
                    if (dec_branch) begin
                        pc_we  = alu_zero;
                        pc_sel = PC_SEL_BRANCH;
                    end else if (dec_jal) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_JUMP;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = dec_store;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    wb_sel = dec_wb_sel;
                end
                ST_ERROR: begin
                    err = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                ST_TRAP: begin
                    trap = 1'b1;
                end
`endif
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

    // dec_legal is implied by the class flags; kept for debug visibility.
    logic legal_unused;
    assign legal_unused = dec_legal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed self-checking bench for multicycle_ctrl.
//
// Each step drives the inputs on the falling clock edge, pushes the outputs
// the controller must show in that cycle onto a scoreboard, and compares
// them just after, well clear of the rising edge. The DUT is built with
// MEM_TIMEOUT_CYCLES = 4. Works with or without MULTICYCLE_CTRL_TRAP_EN.

module tb_multicycle_ctrl;
    import cpu_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [2:0] alu_op;
        logic       alu_b_sel;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       err;
        logic       trap;
    } outs_t;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_SW   = 32'h0010_2023;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_b_sel, reg_we, err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  alu_op;
    logic        trap;

    outs_t exp_q[$];
    string tag_q[$];
    int    check_cnt = 0;
    int    pass_cnt  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .err       (err)
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , .trap    (trap)
`endif
    );

`ifndef MULTICYCLE_CTRL_TRAP_EN
    assign trap = 1'b0;
`endif

    function automatic outs_t exp_idle();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t exp_fetch(input logic rdy);
        outs_t o;
        o = '0;
        o.mem_req = 1'b1;
        o.ir_we   = rdy;
        o.pc_we   = rdy;
        o.pc_sel  = 2'd0;
        return o;
    endfunction

    function automatic outs_t exp_exec(input logic [2:0] op, input logic bsel,
                                       input logic pcwe, input logic [1:0] psel);
        outs_t o;
        o = '0;
        o.alu_op    = op;
        o.alu_b_sel = bsel;
        o.pc_we     = pcwe;
        o.pc_sel    = psel;
        return o;
    endfunction

    function automatic outs_t exp_mem(input logic we);
        outs_t o;
        o = '0;
        o.mem_req  = 1'b1;
        o.addr_sel = 1'b1;
        o.mem_we   = we;
        return o;
    endfunction

    function automatic outs_t exp_wb(input logic [1:0] sel);
        outs_t o;
        o = '0;
        o.reg_we = 1'b1;
        o.wb_sel = sel;
        return o;
    endfunction

    function automatic outs_t exp_err();
        outs_t o;
        o = '0;
        o.err = 1'b1;
        return o;
    endfunction

    function automatic outs_t exp_trap();
        outs_t o;
        o = '0;
        o.trap = 1'b1;
        return o;
    endfunction

    task automatic checkOutput();
        outs_t obs;
        outs_t exp;
        string tag;
        obs = '{mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_op,
                alu_b_sel, reg_we, wb_sel, err, trap};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed=%b required=%b", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] i,
                                 input logic rdy, input logic z,
                                 input outs_t e, input string tag);
        @(negedge clk);
        rst       = r;
        instr     = i;
        mem_ready = rdy;
        alu_zero  = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        checkOutput();
    endtask

    initial begin
        rst       = 1'b1;
        instr     = '0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;

        // Reset holds every output low, even with mem_ready asserted.
        applyStimulus(1, I_ADDI, 0, 0, exp_idle(), "reset_0");
        applyStimulus(1, I_ADDI, 1, 0, exp_idle(), "reset_1");

        // ADDI, memory ready on the first fetch cycle.
        applyStimulus(0, I_ADDI, 1, 0, exp_fetch(1), "addi_fetch");
        applyStimulus(0, I_ADDI, 1, 0, exp_idle(), "addi_decode");
        applyStimulus(0, I_ADDI, 1, 0, exp_exec(ALU_FUNCT, 1, 0, 2'd0), "addi_exec");
        applyStimulus(0, I_ADDI, 1, 0, exp_wb(2'd0), "addi_wb");

        // LW, three MEM waits then ready on the last permitted cycle.
        applyStimulus(0, I_LW, 1, 0, exp_fetch(1), "lw_fetch");
        applyStimulus(0, I_LW, 0, 0, exp_idle(), "lw_decode");
        applyStimulus(0, I_LW, 0, 0, exp_exec(ALU_ADD, 1, 0, 2'd0), "lw_exec");
        applyStimulus(0, I_LW, 0, 0, exp_mem(0), "lw_mem_w0");
        applyStimulus(0, I_LW, 0, 0, exp_mem(0), "lw_mem_w1");
        applyStimulus(0, I_LW, 0, 0, exp_mem(0), "lw_mem_w2");
        applyStimulus(0, I_LW, 1, 0, exp_mem(0), "lw_mem_rdy");
        applyStimulus(0, I_LW, 0, 0, exp_wb(2'd1), "lw_wb");

        // SW with one fetch wait state.
        applyStimulus(0, I_SW, 0, 0, exp_fetch(0), "sw_fetch_wait");
        applyStimulus(0, I_SW, 1, 0, exp_fetch(1), "sw_fetch_rdy");
        applyStimulus(0, I_SW, 0, 0, exp_idle(), "sw_decode");
        applyStimulus(0, I_SW, 0, 0, exp_exec(ALU_ADD, 1, 0, 2'd0), "sw_exec");
        applyStimulus(0, I_SW, 1, 0, exp_mem(1), "sw_mem");

        // BEQ taken, then not taken.
        applyStimulus(0, I_BEQ, 1, 0, exp_fetch(1), "beq1_fetch");
        applyStimulus(0, I_BEQ, 0, 1, exp_idle(), "beq1_decode");
        applyStimulus(0, I_BEQ, 0, 1, exp_exec(ALU_SUB, 0, 1, 2'd1), "beq1_exec_taken");
        applyStimulus(0, I_BEQ, 1, 0, exp_fetch(1), "beq2_fetch");
        applyStimulus(0, I_BEQ, 0, 0, exp_idle(), "beq2_decode");
        applyStimulus(0, I_BEQ, 0, 0, exp_exec(ALU_SUB, 0, 0, 2'd1), "beq2_exec_not_taken");

        // JAL writes the PC in EXEC and PC+4 in WB.
        applyStimulus(0, I_JAL, 1, 0, exp_fetch(1), "jal_fetch");
        applyStimulus(0, I_JAL, 0, 0, exp_idle(), "jal_decode");
        applyStimulus(0, I_JAL, 0, 0, exp_exec(ALU_ADD, 0, 1, 2'd2), "jal_exec");
        applyStimulus(0, I_JAL, 0, 0, exp_wb(2'd2), "jal_wb");

        // Unknown opcode 0x7F.
        applyStimulus(0, I_BAD, 1, 0, exp_fetch(1), "bad_fetch");
        applyStimulus(0, I_BAD, 0, 0, exp_idle(), "bad_decode");
        applyStimulus(0, I_BAD, 0, 0, exp_idle(), "bad_exec");
`ifdef MULTICYCLE_CTRL_TRAP_EN
        applyStimulus(0, I_BAD, 1, 0, exp_trap(), "bad_trap_0");
        applyStimulus(0, I_BAD, 1, 0, exp_trap(), "bad_trap_sticky");
`else
        applyStimulus(0, I_BAD, 0, 0, exp_fetch(0), "bad_nop_fetch");
`endif
        applyStimulus(1, I_LW, 0, 0, exp_idle(), "bad_reset");

        // Reset pulsed in the middle of a MEM wait.
        applyStimulus(0, I_LW, 1, 0, exp_fetch(1), "rlw_fetch");
        applyStimulus(0, I_LW, 0, 0, exp_idle(), "rlw_decode");
        applyStimulus(0, I_LW, 0, 0, exp_exec(ALU_ADD, 1, 0, 2'd0), "rlw_exec");
        applyStimulus(0, I_LW, 0, 0, exp_mem(0), "rlw_mem_w0");
        applyStimulus(0, I_LW, 0, 0, exp_mem(0), "rlw_mem_w1");
        applyStimulus(1, I_LW, 1, 0, exp_idle(), "rlw_reset_0");
        applyStimulus(1, I_LW, 1, 0, exp_idle(), "rlw_reset_1");

        // Fetch never acknowledged: four wait cycles, then ERROR for good.
        applyStimulus(0, I_LW, 0, 0, exp_fetch(0), "to_fetch_w0");
        applyStimulus(0, I_LW, 0, 0, exp_fetch(0), "to_fetch_w1");
        applyStimulus(0, I_LW, 0, 0, exp_fetch(0), "to_fetch_w2");
        applyStimulus(0, I_LW, 0, 0, exp_fetch(0), "to_fetch_w3");
        applyStimulus(0, I_LW, 0, 0, exp_err(), "to_error");
        applyStimulus(0, I_LW, 1, 0, exp_err(), "to_error_ready_ignored");
        applyStimulus(0, I_LW, 1, 0, exp_err(), "to_error_sticky");

        // Only reset leaves ERROR.
        applyStimulus(1, I_ADDI, 0, 0, exp_idle(), "err_reset");
        applyStimulus(0, I_ADDI, 1, 0, exp_fetch(1), "err_recover_fetch");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
